// File: rtl/if_fetch_queue_if.sv
// Fetch-side bundle: instruction-memory request/response bus plus the ID-stage handshake.
interface if_fetch_queue_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt;
   logic          imem_rvalid;
   logic [DW-1:0] imem_rdata;
   logic          id_valid;
   logic          id_ready;
   logic [DW-1:0] id_instr;
   logic [AW-1:0] id_pc;

   modport master (
      output imem_req, imem_addr, id_valid, id_instr, id_pc,
      input  imem_gnt, imem_rvalid, imem_rdata, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_instr, id_pc,
      output imem_gnt, imem_rvalid, imem_rdata, id_ready
   );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch unit: delayed-branch PC/nPC, credit-limited memory requests,
// in-order tag FIFO and an instruction queue toward ID, with flush and response dropping.
module if_fetch_queue #(
   parameter int            AW       = 32,
   parameter int            DW       = 32,
   parameter int            DEPTH    = 4,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic                    clk,
   input  logic                    R,
   input  logic                    redirect_i,
   input  logic [1:0]              redirect_sel_i,
   input  logic [AW-1:0]           alu_out_i,
   input  logic [AW-1:0]           ta_i,
   input  logic                    flush_i,
   output logic [$clog2(DEPTH):0]  count_o,
   if_fetch_queue_if.master        bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

   logic [AW-1:0] pc_q, pc_d, npc_q, npc_d, pend_q, pend_d;
   logic          pend_vld_q, pend_vld_d;
   logic [CW-1:0] cnt_q, cnt_d, outst_q, outst_d, drop_q, drop_d;
   logic [PW-1:0] qwr_q, qwr_d, qrd_q, qrd_d, twr_q, twr_d, trd_q, trd_d;
   logic [DW-1:0] qins_q [DEPTH];
   logic [AW-1:0] qpc_q  [DEPTH];
   logic [AW-1:0] tag_q  [DEPTH];

   logic          req, hs, rsp, push, pop, rd_vld;
   logic [AW-1:0] rd_raw, rd_tgt, ta_al;
   logic [CW:0]   credit_used;

   // Credits cover both queued entries and responses still owed, so pushes never overflow.
   assign credit_used = {1'b0, cnt_q} + {1'b0, outst_q};
   assign req    = R && (credit_used < DEPTH_W);
   assign hs     = req && bus.imem_gnt;
   assign rsp    = bus.imem_rvalid && (outst_q != '0);
   assign push   = rsp && !flush_i && (drop_q == '0);
   assign pop    = (cnt_q != '0) && bus.id_ready && !flush_i;

   assign rd_vld = redirect_i && (redirect_sel_i == 2'b01 || redirect_sel_i == 2'b10);
   assign rd_raw = (redirect_sel_i == 2'b01) ? alu_out_i : ta_i;
   assign rd_tgt = rd_raw & ~AW'(3);
   assign ta_al  = ta_i & ~AW'(3);

   assign bus.imem_req  = req;
   assign bus.imem_addr = pc_q;
   assign bus.id_valid  = (cnt_q != '0);
   assign bus.id_instr  = (cnt_q != '0) ? qins_q[qrd_q] : '0;
   assign bus.id_pc     = (cnt_q != '0) ? qpc_q[qrd_q]  : '0;
   assign count_o       = cnt_q;

   always_comb begin
      pc_d       = pc_q;
      npc_d      = npc_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      cnt_d      = cnt_q + CW'(push) - CW'(pop);
      qwr_d      = qwr_q + PW'(push);
      qrd_d      = qrd_q + PW'(pop);
      outst_d    = outst_q + CW'(hs) - CW'(rsp);
      twr_d      = twr_q + PW'(hs);
      trd_d      = trd_q + PW'(rsp);
      drop_d     = drop_q - CW'(rsp && (drop_q != '0));
      if (flush_i) begin
         // Everything owed at the end of this cycle, including a grant taken now, gets dropped.
         cnt_d      = '0;
         qwr_d      = '0;
         qrd_d      = '0;
         pend_vld_d = 1'b0;
         pc_d       = ta_al;
         npc_d      = ta_al + AW'(4);
         drop_d     = outst_d;
      end else if (hs) begin
         pc_d       = npc_q;
         pend_vld_d = 1'b0;
         if (rd_vld)          npc_d = rd_tgt;
         else if (pend_vld_q) npc_d = pend_q;
         else                 npc_d = npc_q + AW'(4);
      end else if (rd_vld) begin
         pend_vld_d = 1'b1;
         pend_d     = rd_tgt;
      end
   end

   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         pc_q       <= RESET_PC;
         npc_q      <= RESET_PC + AW'(4);
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         cnt_q      <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
         qwr_q      <= '0;
         qrd_q      <= '0;
         twr_q      <= '0;
         trd_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         npc_q      <= npc_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         cnt_q      <= cnt_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         qwr_q      <= qwr_d;
         qrd_q      <= qrd_d;
         twr_q      <= twr_d;
         trd_q      <= trd_d;
      end
   end

   // Payload storage needs no reset: occupancy and pointers decide what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         qins_q[qwr_q] <= bus.imem_rdata;
         qpc_q[qwr_q]  <= tag_q[trd_q];
      end
      if (hs) tag_q[twr_q] <= pc_q;
   end
endmodule
